// File: rtl/cen_accumulator_if.sv
// Sample/sum bus between the centering accumulator and its producer/consumer.
// Carries the ovf flag only when CEN_ACC_OVF_EN is defined.
interface cen_accumulator_if #(
  parameter int SAMPLE_W = 26,
  parameter int SUM_W    = 40,
  parameter int N_LOG2   = 7
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] x1, x2, x3, x4;
  logic [SUM_W-1:0]    sum1, sum2, sum3, sum4;
  logic                div_en;
  logic                busy;
  logic [N_LOG2:0]     cnt;
`ifdef CEN_ACC_OVF_EN
  logic                ovf;

  modport master (
    output start, in_valid, x1, x2, x3, x4,
    input  in_ready, sum1, sum2, sum3, sum4, div_en, busy, cnt, ovf
  );
  modport slave (
    input  start, in_valid, x1, x2, x3, x4,
    output in_ready, sum1, sum2, sum3, sum4, div_en, busy, cnt, ovf
  );
`else
  modport master (
    output start, in_valid, x1, x2, x3, x4,
    input  in_ready, sum1, sum2, sum3, sum4, div_en, busy, cnt
  );
  modport slave (
    input  start, in_valid, x1, x2, x3, x4,
    output in_ready, sum1, sum2, sum3, sum4, div_en, busy, cnt
  );
`endif
endinterface

// File: rtl/cen_accumulator.sv
// Four-channel block accumulator feeding the divide-by-2**N_LOG2 mean unit.
// CEN_ACC_OVF_EN: adds sticky ovf and per-channel saturation on carry-out.
//
// state | meaning
// IDLE  | waiting for start; sums hold last block result
// ACC   | accepting sample sets until 2**N_LOG2 have been summed
// FIN   | one cycle, div_en high, sums final
module cen_accumulator #(
  parameter int SAMPLE_W = 26,
  parameter int SUM_W    = 40,
  parameter int N_LOG2   = 7
) (
  input logic              clk,
  input logic              rst_n,
  cen_accumulator_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_t;

`ifdef CEN_ACC_OVF_EN
  localparam int ADD_W = SUM_W + 1;
`else
  localparam int ADD_W = SUM_W;
`endif
  localparam logic [N_LOG2:0] LAST_CNT = (N_LOG2+1)'((1 << N_LOG2) - 1);

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    sum_q [4];
  logic [SUM_W-1:0]    sum_d [4];
  logic [SAMPLE_W-1:0] x [4];
  logic [ADD_W-1:0]    add_w [4];
  logic [N_LOG2:0]     cnt_q, cnt_d;
  logic                accept;
`ifdef CEN_ACC_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  assign x[0] = bus.x1;
  assign x[1] = bus.x2;
  assign x[2] = bus.x3;
  assign x[3] = bus.x4;

  assign accept = (state_q == ACC) && bus.in_valid;

  // Widened by one bit only when the carry-out is needed for saturation.
  for (genvar k = 0; k < 4; k++) begin : g_add
    assign add_w[k] = ADD_W'(sum_q[k]) + ADD_W'(x[k]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
`ifdef CEN_ACC_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACC;
          cnt_d   = '0;
          for (int k = 0; k < 4; k++) sum_d[k] = '0;
`ifdef CEN_ACC_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      ACC: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          for (int k = 0; k < 4; k++) begin
`ifdef CEN_ACC_OVF_EN
            if (add_w[k][SUM_W]) begin
              sum_d[k] = '1;
              ovf_d    = 1'b1;
            end else begin
              sum_d[k] = add_w[k][SUM_W-1:0];
            end
`else
            sum_d[k] = add_w[k];
`endif
          end
          if (cnt_q == LAST_CNT) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < 4; k++) sum_q[k] <= '0;
`ifdef CEN_ACC_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
`ifdef CEN_ACC_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // div_en decodes the registered state, so it never follows an input combinationally.
  assign bus.in_ready = (state_q == ACC);
  assign bus.busy     = (state_q != IDLE);
  assign bus.div_en   = (state_q == FIN);
  assign bus.cnt      = cnt_q;
  assign bus.sum1     = sum_q[0];
  assign bus.sum2     = sum_q[1];
  assign bus.sum3     = sum_q[2];
  assign bus.sum4     = sum_q[3];
`ifdef CEN_ACC_OVF_EN
  assign bus.ovf      = ovf_q;
`endif
endmodule

// File: tb/tb_cen_accumulator.sv
// Self-checking bench for cen_accumulator: directed blocks with random data/gaps
// compared against an arithmetic per-block sum model.
module tb_cen_accumulator;
  localparam int SW   = 26;
  localparam int SUMW = 40;
  localparam int NL   = 7;
  localparam int BLK  = 1 << NL;
  localparam int BUDGET = 2000;
  localparam logic [63:0] MASK = (64'd1 << SUMW) - 64'd1;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  logic [63:0] exp_s [4];

  always #5 clk = ~clk;

  cen_accumulator_if #(.SAMPLE_W(SW), .SUM_W(SUMW), .N_LOG2(NL)) bus ();

  cen_accumulator #(.SAMPLE_W(SW), .SUM_W(SUMW), .N_LOG2(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] dut_sum(input int k);
    case (k)
      0:       return 64'(bus.sum1);
      1:       return 64'(bus.sum2);
      2:       return 64'(bus.sum3);
      default: return 64'(bus.sum4);
    endcase
  endfunction

  task automatic check_sums(input string tag);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_sum%0d", tag, k + 1), dut_sum(k), exp_s[k]);
  endtask

  // Sample value for channel ch of the i-th accepted set under a stimulus mode.
  function automatic logic [SW-1:0] gen(input int mode, input int ch, input int i);
    case (mode)
      0:       return SW'(ch + 1);
      1:       return '1;
      2:       return SW'(i);
      3:       return SW'(5);
      default: return SW'($urandom);
    endcase
  endfunction

  task automatic drive_x(input logic [SW-1:0] v [4]);
    bus.x1 = v[0];
    bus.x2 = v[1];
    bus.x3 = v[2];
    bus.x4 = v[3];
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state_busy"}, bus.busy, 0);
    chk({tag, "_ready"}, bus.in_ready, 0);
    chk({tag, "_div_en"}, bus.div_en, 0);
    chk({tag, "_cnt"}, bus.cnt, 0);
    for (int k = 0; k < 4; k++) exp_s[k] = 0;
    check_sums(tag);
`ifdef CEN_ACC_OVF_EN
    chk({tag, "_ovf"}, bus.ovf, 0);
`endif
  endtask

  // Called at a negedge with the DUT in IDLE. gap: 0 continuous, 1 toggle, 2 random.
  // inject_at: pulse start together with that accept. stop_after: return mid-block.
  task automatic run_block(input string tag, input int mode, input int gap, input int inject_at,
                           input bit start_in_fin, input int stop_after);
    int n;
    int cyc;
    bit v;
    logic [SW-1:0] xv [4];
    bus.start = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) exp_s[k] = 0;
    chk({tag, "_start_ready"}, bus.in_ready, 1);
    chk({tag, "_start_cnt"}, bus.cnt, 0);
    check_sums({tag, "_clr"});
    n = 0;
    cyc = 0;
    while (n < BLK && cyc < BUDGET) begin
      if (stop_after != 0 && n == stop_after) return;
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      for (int k = 0; k < 4; k++) xv[k] = v ? gen(mode, k, n) : SW'($urandom);
      if (v) begin
        for (int k = 0; k < 4; k++) exp_s[k] = (exp_s[k] + 64'(xv[k])) & MASK;
        n++;
      end
      drive_x(xv);
      bus.in_valid = v;
      bus.start = (inject_at != 0 && v && n == inject_at);
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (n < BLK) begin
        chk({tag, "_acc_ready"}, bus.in_ready, 1);
        chk({tag, "_acc_div_en"}, bus.div_en, 0);
        chk({tag, "_acc_cnt"}, bus.cnt, 64'(n));
        check_sums({tag, "_acc"});
      end
    end
    if (n < BLK) chk({tag, "_budget_accepts"}, 64'(n), 64'(BLK));
    if (gap == 0) chk({tag, "_latency"}, 64'(cyc), 64'(BLK));
    bus.in_valid = 1'b0;
    chk({tag, "_fin_div_en"}, bus.div_en, 1);
    chk({tag, "_fin_ready"}, bus.in_ready, 0);
    chk({tag, "_fin_busy"}, bus.busy, 1);
    chk({tag, "_fin_cnt"}, bus.cnt, 64'(BLK));
    check_sums({tag, "_fin"});
    bus.start = start_in_fin;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_idle_div_en"}, bus.div_en, 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_idle_ready"}, bus.in_ready, 0);
    chk({tag, "_idle_cnt"}, bus.cnt, 64'(BLK));
    check_sums({tag, "_idle"});
`ifdef CEN_ACC_OVF_EN
    chk({tag, "_ovf"}, bus.ovf, 0);
`endif
    if (start_in_fin) begin
      @(negedge clk);
      chk({tag, "_fin_start_ignored"}, bus.busy, 0);
      check_sums({tag, "_hold"});
    end
  endtask

  initial begin
    logic [SW-1:0] xv [4];
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) xv[k] = SW'($urandom);
    drive_x(xv);
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("por_idle_busy", bus.busy, 0);

    run_block("t1_const", 0, 0, 0, 1'b0, 0);
    chk("t1_sum1_abs", bus.sum1, 64'd128);
    chk("t1_sum4_abs", bus.sum4, 64'd512);

    run_block("t2_max", 1, 0, 0, 1'b0, 0);
    chk("t2_sum_abs", bus.sum2, 64'h1FFFFFF80);

    run_block("t3_ramp", 2, 1, 0, 1'b0, 0);
    chk("t3_sum_abs", bus.sum3, 64'd8128);

    run_block("t4_part", 4, 2, 0, 1'b0, 50);
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_reset_state("t4_rst");
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_post_busy", bus.busy, 0);
    run_block("t4_restart", 3, 0, 0, 1'b0, 0);
    chk("t4_sum_abs", bus.sum1, 64'd640);

    run_block("t5_inject", 4, 2, 10, 1'b1, 0);
    repeat (5) begin
      for (int k = 0; k < 4; k++) xv[k] = SW'($urandom);
      drive_x(xv);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("t5_idle_ready", bus.in_ready, 0);
      chk("t5_idle_busy", bus.busy, 0);
      chk("t5_idle_cnt", bus.cnt, 64'(BLK));
      check_sums("t5_idle");
    end
    bus.in_valid = 1'b0;

    for (int b = 0; b < 3; b++) run_block($sformatf("rnd%0d", b), 4, 2, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
